// File: rtl/uart_rx_fifo.sv
// UART receiver (5..8 data bits, 1 stop) feeding a first-word-fall-through FIFO; byte visible one clk after stop sample.
// No backpressure: a byte arriving at a full FIFO without a same-cycle pop is dropped and flagged as overrun.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      UBRR,
    input  logic [3:0]       UCSZ,
    input  logic             rx_en,
    input  logic             rx,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [CNT_W-1:0] fifo_count,
    output logic             frame_err,
    output logic             overrun
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic               rx_m_q, rx_s_q;
    logic [11:0]        cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         sh_q, sh_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               frame_err_q, frame_err_d, overrun_q, overrun_d;

    logic [11:0]        n_eff;
    logic [2:0]         last_idx;
    logic [7:0]         rx_byte;
    logic               cnt_zero, push, ferr_set, pop, full, push_ok, ovr_set;

    assign n_eff    = (UBRR < 12'd4) ? 12'd4 : UBRR;
    assign cnt_zero = (cnt_q == 12'd0);

    always_comb begin
        last_idx = 3'd7;
        case (UCSZ)
            4'd5:    last_idx = 3'd4;
            4'd6:    last_idx = 3'd5;
            4'd7:    last_idx = 3'd6;
            default: last_idx = 3'd7;
        endcase
    end

    // Bits enter at sh[7], so a short frame sits in the top bits and is realigned here.
    assign rx_byte = sh_q >> (3'd7 - last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            sh_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rx_m_q      <= rx;
            rx_s_q      <= rx_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            sh_q        <= sh_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        if (state_q != IDLE && !rx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rx_en && !rx_s_q) begin
                    state_d = START;
                    cnt_d   = (n_eff >> 1) - 12'd1;
                end
                START: begin
                    if (!cnt_zero) cnt_d = cnt_q - 12'd1;
                    else if (!rx_s_q) begin
                        state_d   = DATA;
                        cnt_d     = n_eff - 12'd1;
                        bit_idx_d = 3'd0;
                    end else state_d = IDLE;
                end
                DATA: begin
                    if (!cnt_zero) cnt_d = cnt_q - 12'd1;
                    else begin
                        sh_d      = {rx_s_q, sh_q[7:1]};
                        cnt_d     = n_eff - 12'd1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == last_idx) state_d = STOP;
                    end
                end
                STOP: begin
                    if (!cnt_zero) cnt_d = cnt_q - 12'd1;
                    else state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        push     = 1'b0;
        ferr_set = 1'b0;
        if (rx_en && state_q == STOP && cnt_zero) begin
            push     = rx_s_q;
            ferr_set = !rx_s_q;
        end
    end

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = rd_en && (count_q != '0);
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = rx_byte;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as err_clr keeps its flag set.
        frame_err_d = (frame_err_q && !err_clr) || ferr_set;
        overrun_d   = (overrun_q && !err_clr) || ovr_set;
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'd0;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven on negedges, outputs checked on negedges.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic [11:0] UBRR;
    logic [3:0] UCSZ;
    logic       rx_en, rx, rd_en, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_err, overrun;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .UBRR(UBRR), .UCSZ(UCSZ), .rx_en(rx_en), .rx(rx),
        .rd_en(rd_en), .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pop_at_stop raises rd_en for exactly the cycle in which the stop bit is sampled.
    task automatic send_frame(input logic [7:0] d, input int nb, input logic stop_b, input logic pop_at_stop);
        int n;
        int h;
        n = int'(UBRR);
        h = n / 2;
        @(negedge clk);
        rx = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (n) @(negedge clk);
        end
        rx = stop_b;
        for (int i = 0; i < n; i++) begin
            rd_en = pop_at_stop && (i == h + 2);
            @(negedge clk);
        end
        rd_en = 1'b0;
        rx    = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop1;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        string msg;
        msg     = "Hello world!";
        rst     = 1'b1;
        UBRR    = 12'd868;
        UCSZ    = 4'd8;
        rx_en   = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // T1: slow baud, one byte
        send_frame(8'h48, 8, 1'b1, 1'b0);
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'h48);
        chk("t1_count", fifo_count, 1);
        pop1();
        chk("t1_valid_after_pop", rx_valid, 0);
        chk("t1_data_empty", rx_data, 0);

        // T2: string at UBRR=16, read each byte as it arrives
        UBRR = 12'd16;
        for (int i = 0; i < 12; i++) begin
            send_frame(msg[i], 8, 1'b1, 1'b0);
            chk($sformatf("t2_byte%0d", i), rx_data, msg[i]);
            pop1();
        end
        chk("t2_count", fifo_count, 0);
        chk("t2_ferr", frame_err, 0);
        chk("t2_ovr", overrun, 0);

        // T3: 5-bit frames, stop-bit error, err_clr, illegal UCSZ acts as 8
        UCSZ = 4'd5;
        send_frame(8'h15, 5, 1'b1, 1'b0);
        chk("t3_data5", rx_data, 8'h15);
        send_frame(8'h0A, 5, 1'b0, 1'b0);
        chk("t3_ferr", frame_err, 1);
        chk("t3_count", fifo_count, 1);
        chk("t3_head_kept", rx_data, 8'h15);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_ferr_clr", frame_err, 0);
        pop1();
        UCSZ = 4'd12;
        send_frame(8'hC3, 8, 1'b1, 1'b0);
        chk("t3_ucsz_dflt", rx_data, 8'hC3);
        pop1();
        UCSZ = 4'd8;

        // T4: overflow with no reads
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 1'b1, 1'b0);
        chk("t4_count", fifo_count, 4);
        chk("t4_ovr", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t4_pop%0d", i), rx_data, i);
            pop1();
        end
        chk("t4_empty", fifo_count, 0);
        chk("t4_ovr_sticky", overrun, 1);

        // T5: glitch shorter than half a bit, then rx_en dropped mid-frame
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        chk("t5_glitch_count", fifo_count, 0);
        chk("t5_glitch_ferr", frame_err, 0);
        send_frame(8'h5A, 8, 1'b1, 1'b0);
        chk("t5_after_glitch", rx_data, 8'h5A);
        pop1();
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = 1'b0;
            if (i == 3) rx_en = 1'b0;
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (48) @(negedge clk);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_rxen_count", fifo_count, 0);
        chk("t5_rxen_ferr", frame_err, 0);

        // T6: reset mid-frame clears everything, including the sticky overrun
        send_frame(8'h11, 8, 1'b1, 1'b0);
        chk("t6_pre_count", fifo_count, 1);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'hA5 >> i) & 8'h01) != 0;
            repeat (16) @(negedge clk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_ovr", overrun, 0);
        chk("t6_rst_ferr", frame_err, 0);
        send_frame(8'h3C, 8, 1'b1, 1'b0);
        chk("t6_clean", rx_data, 8'h3C);
        chk("t6_clean_count", fifo_count, 1);
        pop1();

        // Full FIFO, pop coincides with push
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 8, 1'b1, 1'b0);
        chk("t6_full", fifo_count, 4);
        send_frame(8'h14, 8, 1'b1, 1'b1);
        chk("t6_pp_count", fifo_count, 4);
        chk("t6_pp_ovr", overrun, 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t6_pp_pop%0d", i), rx_data, 8'h10 + i);
            pop1();
        end
        chk("t6_final_empty", rx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
